// File: rtl/logic_unit_sliced_pkg.sv
// Shared encodings for the sliced logic unit: opcodes and FSM states.
package logic_unit_sliced_pkg;

  typedef enum logic [2:0] {
    OP_NOT = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_NEG = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_sliced_slice.sv
// One SLICE-bit lane of the logic unit; NEG is ~a + cin with a carry chained across slices.
module logic_slice
  import logic_unit_sliced_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [SLICE-1:0] y,
  output logic             cout
);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NEG: {cout, y} = {1'b0, ~a} + {{SLICE{1'b0}}, cin};
      default: ;
    endcase
  end

endmodule

// File: rtl/logic_unit_sliced.sv
// Multi-cycle bitwise/negate unit: one shared slice walks the latched operands SLICE bits per clock.
module logic_unit_sliced
  import logic_unit_sliced_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Rz
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("logic_unit_sliced: WIDTH must be a multiple of SLICE");
  end

  state_e           state, state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] ra_q, rb_q, res;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             cout;

  assign a_sl = ra_q[int'(idx)*SLICE +: SLICE];
  assign b_sl = rb_q[int'(idx)*SLICE +: SLICE];
  assign busy = (state == S_RUN);

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .op   (op_q),
    .cin  (carry),
    .y    (y_sl),
    .cout (cout)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (idx == LAST) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Rz is only touched in FIN so consumers never see a half-written result.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ra_q  <= '0;
      rb_q  <= '0;
      op_q  <= '0;
      res   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      Rz    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ra_q  <= Ra;
          rb_q  <= Rb;
          op_q  <= op;
          idx   <= '0;
          carry <= 1'b1;
          err   <= 1'b0;
        end
        S_RUN: begin
          res[int'(idx)*SLICE +: SLICE] <= y_sl;
          carry <= cout;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        S_FIN: begin
          done <= 1'b1;
          if (op_q > 3'd4) begin
            err <= 1'b1;
            Rz  <= '0;
          end else begin
            Rz  <= res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_sliced.sv
// Scoreboard bench: three instances (SLICE 8/32/4) share operands; a monitor checks every done.
module tb_logic_unit_sliced;
  import logic_unit_sliced_pkg::*;

  typedef struct {
    int          dut;
    logic [31:0] rz;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [2:0]  start_v;
  logic [2:0]  op;
  logic [31:0] Ra, Rb;
  logic [2:0]  busy_v, done_v, err_v;
  logic [31:0] rz_v [3];

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bcnt [3] = '{0, 0, 0};
  int   done_cnt [3] = '{0, 0, 0};
  int   NS [3] = '{4, 1, 8};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic_unit_sliced #(.WIDTH(32), .SLICE(8)) dut0 (
    .clock(clock), .clear(clear), .start(start_v[0]), .op(op), .Ra(Ra), .Rb(Rb),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .Rz(rz_v[0]));
  logic_unit_sliced #(.WIDTH(32), .SLICE(32)) dut1 (
    .clock(clock), .clear(clear), .start(start_v[1]), .op(op), .Ra(Ra), .Rb(Rb),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .Rz(rz_v[1]));
  logic_unit_sliced #(.WIDTH(32), .SLICE(4)) dut2 (
    .clock(clock), .clear(clear), .start(start_v[2]), .op(op), .Ra(Ra), .Rb(Rb),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .Rz(rz_v[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks value, err, latency and busy length.
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (!clear)          bcnt[d] = 0;
      else if (busy_v[d])  bcnt[d]++;
      if (done_v[d]) begin
        done_cnt[d]++;
        if (q.size() == 0 || q[0].dut != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: dut%0d Rz=%h at cycle %0d, none expected", d, rz_v[d], cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("rz_dut%0d", d), rz_v[d], e.rz);
          chk($sformatf("err_dut%0d", d), 32'(err_v[d]), 32'(e.err));
          chk($sformatf("latency_dut%0d", d), 32'(cyc), 32'(e.cyc));
          chk($sformatf("busy_len_dut%0d", d), 32'(bcnt[d]), 32'(NS[d]));
          chk($sformatf("busy_at_done_dut%0d", d), 32'(busy_v[d]), 32'd0);
        end
        bcnt[d] = 0;
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_rz, input logic exp_err);
    exp_t e;
    @(negedge clock);
    op = o; Ra = a; Rb = b;
    start_v[d] = 1'b1;
    @(posedge clock);
    #1;
    start_v[d] = 1'b0;
    e.dut = d; e.rz = exp_rz; e.err = exp_err; e.cyc = cyc + NS[d] + 1;
    q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int dc;
    clear = 1'b0; start_v = '0; op = '0; Ra = '0; Rb = '0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_rz_dut%0d", d), rz_v[d], 32'h0);
      chk($sformatf("reset_flags_dut%0d", d), {29'd0, busy_v[d], done_v[d], err_v[d]}, 32'h0);
    end
    clear = 1'b1;
    @(negedge clock);

    issue(0, OP_NOT, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0); drain();
    issue(0, OP_NOT, 32'hAAAA_AAAA, 32'h0, 32'h5555_5555, 1'b0); drain();
    issue(0, OP_NOT, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b0); drain();
    issue(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0); drain();
    issue(0, OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0); drain();
    issue(0, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0); drain();
    issue(0, OP_NEG, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0); drain();
    issue(0, OP_NEG, 32'h0000_0100, 32'h0, 32'hFFFF_FF00, 1'b0); drain();
    issue(0, OP_NEG, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0); drain();
    issue(0, OP_NEG, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0); drain();

    // Second start and operand change while running must not disturb the result.
    issue(0, OP_NOT, 32'h1234_5678, 32'h0, 32'hEDCB_A987, 1'b0);
    @(negedge clock); @(negedge clock);
    start_v[0] = 1'b1; op = OP_AND; Ra = 32'h0;
    @(negedge clock);
    start_v[0] = 1'b0;
    drain();
    repeat (10) @(negedge clock);

    // Abort in flight: accept, let two slices be written, then clear.
    dc = done_cnt[0];
    @(negedge clock);
    op = OP_NOT; Ra = 32'h0; start_v[0] = 1'b1;
    @(posedge clock); #1; start_v[0] = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("busy_before_abort", 32'(busy_v[0]), 32'd1);
    clear = 1'b0;
    #1;
    chk("abort_rz", rz_v[0], 32'h0);
    chk("abort_flags", {29'd0, busy_v[0], done_v[0], err_v[0]}, 32'h0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    repeat (10) @(negedge clock);
    chk("abort_no_done", 32'(done_cnt[0]), 32'(dc));

    // Illegal op: err held until the next accepted start.
    issue(0, 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b1); drain();
    repeat (3) @(negedge clock);
    chk("err_held", 32'(err_v[0]), 32'd1);
    issue(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    chk("err_cleared_on_start", 32'(err_v[0]), 32'd0);
    drain();

    for (int d = 1; d < 3; d++) begin
      issue(d, OP_NOT, 32'hAAAA_AAAA, 32'h0, 32'h5555_5555, 1'b0); drain();
      issue(d, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0); drain();
      issue(d, OP_NEG, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0); drain();
      issue(d, OP_NEG, 32'h0000_0100, 32'h0, 32'hFFFF_FF00, 1'b0); drain();
      issue(d, 3'd6, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1); drain();
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
